// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for a multicycle CPU load/store path. It accepts a
// read or write strobe in IDLE, optionally waits LATENCY cycles, and then
// returns a one-cycle Ready pulse. A read returns data on R_data; a bad
// request raises Err.
//
// Ports:
//   CLK     rising-edge clock
//   Rst     asynchronous active-high reset
//   Addr    byte address; the word index is Addr[ADDR_W+1:2]
//   W_data  write data
//   R, W    read / write strobes, sampled only in IDLE
//   R_data  registered read data, held between reads
//   Ready   one-cycle response pulse
//   Err     error qualifier, meaningful only while Ready is high
//   Busy    high whenever the responder is not in IDLE
//
// Configuration macro: MEM_RESP_WAIT_EN
//   When defined, the WAIT state and its wait counter are present and
//   LATENCY is honoured. When undefined, every accepted request goes
//   straight to RESP and LATENCY is ignored.
module mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        CLK,
   input  logic        Rst,
   input  logic [31:0] Addr,
   input  logic [31:0] W_data,
   input  logic        R,
   input  logic        W,
   output logic [31:0] R_data,
   output logic        Ready,
   output logic        Err,
   output logic        Busy
);

`ifdef MEM_RESP_WAIT_EN
   typedef enum logic [1:0] {IDLE, WAIT_S, RESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

   state_t             state_q, state_d;
   logic [31:0]        r_data_q, r_data_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic [31:0]        mem_q [2**ADDR_W];

   logic [ADDR_W-1:0]  in_idx;
   logic               in_bad;
   logic               enter_resp;
   logic [ADDR_W-1:0]  c_idx;
   logic [31:0]        c_wdata;
   logic               c_wr;
   logic               c_rd;
   logic               c_bad;
   logic               mem_we;

`ifdef MEM_RESP_WAIT_EN
   logic [3:0]         cnt_q, cnt_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               wr_q, wr_d;
   logic               bad_q, bad_d;
`endif

   assign in_idx = Addr[ADDR_W+1:2];
   // A request is bad if misaligned, ambiguous (both strobes) or if any
   // address bit above the array range is set.
   assign in_bad = (Addr[1:0] != 2'b00) || (R && W) ||
                   ((Addr >> (ADDR_W + 2)) != 32'd0);

   always_comb begin
      state_d    = state_q;
      enter_resp = 1'b0;
      c_idx      = in_idx;
      c_wdata    = W_data;
      c_wr       = 1'b0;
      c_rd       = 1'b0;
      c_bad      = 1'b0;
`ifdef MEM_RESP_WAIT_EN
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      bad_d      = bad_q;
`endif
      case (state_q)
         IDLE: begin
            if (R || W) begin
`ifdef MEM_RESP_WAIT_EN
               idx_d   = in_idx;
               wdata_d = W_data;
               wr_d    = W;
               bad_d   = in_bad;
               if (LATENCY == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
                  c_wr       = W && !in_bad;
                  c_rd       = R && !in_bad;
                  c_bad      = in_bad;
               end else begin
                  state_d = WAIT_S;
                  cnt_d   = 4'(LATENCY - 1);
               end
`else
               state_d    = RESP;
               enter_resp = 1'b1;
               c_wr       = W && !in_bad;
               c_rd       = R && !in_bad;
               c_bad      = in_bad;
`endif
            end
         end
`ifdef MEM_RESP_WAIT_EN
         WAIT_S: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
               c_idx      = idx_q;
               c_wdata    = wdata_q;
               c_wr       = wr_q && !bad_q;
               c_rd       = !wr_q && !bad_q;
               c_bad      = bad_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Commit must never happen while reset is held, even if a strobe is up.
      mem_we   = c_wr && !Rst;
      r_data_d = c_rd ? mem_q[c_idx] : r_data_q;
      ready_d  = enter_resp;
      err_d    = enter_resp && c_bad;
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         r_data_q <= 32'd0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef MEM_RESP_WAIT_EN
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         wdata_q  <= 32'd0;
         wr_q     <= 1'b0;
         bad_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         r_data_q <= r_data_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
`ifdef MEM_RESP_WAIT_EN
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         bad_q    <= bad_d;
`endif
      end
   end

   // Storage is deliberately not reset; contents are undefined until written.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem_q[c_idx] <= c_wdata;
      end
   end

   assign R_data = r_data_q;
   assign Ready  = ready_q;
   assign Err    = err_q;
   assign Busy   = busy_q;

endmodule
